// File: rtl/memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_unit (with fcpu_pkg)
//  Description : Runs stores, loads, I_OUTPUT and input-port loads against a
//                single-port data RAM and the byte-stream ports; loads report
//                their results on the CDB.
//  Revision    : 1.0 - initial release
// ============================================================================

package fcpu_pkg;
    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_LOAD    = 6'h01;
    localparam logic [INSTR_W-1:0] I_LOADB   = 6'h02;
    localparam logic [INSTR_W-1:0] I_STORE   = 6'h03;
    localparam logic [INSTR_W-1:0] I_STOREB  = 6'h04;
    localparam logic [INSTR_W-1:0] I_STORER  = 6'h05;
    localparam logic [INSTR_W-1:0] I_STORET  = 6'h06;
    localparam logic [INSTR_W-1:0] I_STORETB = 6'h07;
    localparam logic [INSTR_W-1:0] I_OUTPUT  = 6'h08;
endpackage

module memory_access_unit
    import fcpu_pkg::*;
#(
    parameter int MEM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [INSTR_W-1:0]    i_opcode,
    input  logic [RSV_ID_W-1:0]   i_rsv_id,
    input  logic [DATA_W-1:0]     i_address,
    input  logic [DATA_W-1:0]     i_data,
    output logic                  i_ready,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic [CDB_W-1:0]      o_cdb,
    output logic                  o_cdb_valid,
    input  logic                  o_cdb_ready
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_WAIT = 3'd1,
        S_IN_WAIT   = 3'd2,
        S_OUT_WAIT  = 3'd3,
        S_RESP      = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_W-1:0]     r_result;
    logic [RSV_ID_W-1:0]   r_rsv_id;
    logic [DATA_W-1:0]     r_out_data;

    logic w_idle;
    logic w_accept;
    logic w_is_store;
    logic w_is_output;
    logic w_is_input;

    // Outputs stay quiet while reset is held, so acceptance is gated by rst too.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_accept    = i_valid && w_idle;
    assign w_is_store  = (i_opcode == I_STORE)  || (i_opcode == I_STOREB) ||
                         (i_opcode == I_STORER) || (i_opcode == I_STORET) ||
                         (i_opcode == I_STORETB);
    assign w_is_output = (i_opcode == I_OUTPUT);
    assign w_is_input  = !w_is_store && !w_is_output && (&i_address);

    always_comb begin
        w_next      = r_state;
        i_ready     = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        in_ready    = 1'b0;
        o_cdb       = '0;
        o_cdb_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                i_ready = w_idle;
                if (w_accept) begin
                    if (w_is_store) begin
                        mem_en    = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = i_address[MEM_ADDR_W-1:0];
                        mem_wdata = i_data;
                    end else if (w_is_output) begin
                        w_next = S_OUT_WAIT;
                    end else if (w_is_input) begin
                        w_next = S_IN_WAIT;
                    end else begin
                        mem_en   = 1'b1;
                        mem_addr = i_address[MEM_ADDR_W-1:0];
                        w_next   = S_LOAD_WAIT;
                    end
                end
            end
            S_LOAD_WAIT: w_next = S_RESP;
            S_IN_WAIT: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RESP;
            end
            S_OUT_WAIT: begin
                out_valid = 1'b1;
                out_data  = r_out_data;
                if (out_ready) w_next = S_IDLE;
            end
            S_RESP: begin
                o_cdb_valid = 1'b1;
                o_cdb       = {r_rsv_id, r_result};
                if (o_cdb_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_rsv_id   <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_is_store) begin
                if (w_is_output) r_out_data <= i_data;
                else             r_rsv_id   <= i_rsv_id;
            end
            if (r_state == S_LOAD_WAIT)           r_result <= mem_rdata;
            if (r_state == S_IN_WAIT && in_valid) r_result <= in_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_unit
//  Description : Directed self-checking bench for memory_access_unit with a
//                behavioural 1-cycle-latency data RAM.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_memory_access_unit;
    import fcpu_pkg::*;

    localparam int MEM_ADDR_W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  i_valid;
    logic [INSTR_W-1:0]    i_opcode;
    logic [RSV_ID_W-1:0]   i_rsv_id;
    logic [DATA_W-1:0]     i_address;
    logic [DATA_W-1:0]     i_data;
    logic                  i_ready;
    logic                  mem_en;
    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  out_valid;
    logic [DATA_W-1:0]     out_data;
    logic                  out_ready;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  in_ready;
    logic [CDB_W-1:0]      o_cdb;
    logic                  o_cdb_valid;
    logic                  o_cdb_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] r_ram [0:(1<<MEM_ADDR_W)-1];

    memory_access_unit #(.MEM_ADDR_W(MEM_ADDR_W)) u_dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_opcode(i_opcode), .i_rsv_id(i_rsv_id),
        .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .o_cdb(o_cdb), .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) r_ram[mem_addr] <= mem_wdata;
            else        mem_rdata       <= r_ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [INSTR_W-1:0] op, input logic [RSV_ID_W-1:0] id,
                             input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] data);
        i_valid   = 1'b1;
        i_opcode  = op;
        i_rsv_id  = id;
        i_address = addr;
        i_data    = data;
    endtask

    task automatic idle_req();
        i_valid = 1'b0;
    endtask

    initial begin
        logic [INSTR_W-1:0] store_ops [4];
        store_ops[0] = I_STORE;
        store_ops[1] = I_STOREB;
        store_ops[2] = I_STORER;
        store_ops[3] = I_STORET;

        rst = 1'b1;
        i_valid = 1'b0; i_opcode = '0; i_rsv_id = '0; i_address = '0; i_data = '0;
        out_ready = 1'b0; in_valid = 1'b0; in_data = '0; o_cdb_ready = 1'b1;
        mem_rdata = '0;

        // Reset state
        @(negedge clk);
        check("rst_cdb_valid", 64'(o_cdb_valid), 64'd0);
        check("rst_mem_en",    64'(mem_en),      64'd0);
        check("rst_out_valid", 64'(out_valid),   64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_i_ready", 64'(i_ready), 64'd1);

        // Test 1: store then load, result 2 cycles after load accept
        next_cycle();
        drive_req(I_STORE, 4'd0, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_st_en",    64'({mem_en, mem_we}), 64'b11);
        check("t1_st_addr",  64'(mem_addr),  64'h10);
        check("t1_st_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        next_cycle();
        drive_req(I_LOAD, 4'd3, 32'h10, 32'h0);
        @(negedge clk);
        check("t1_ld_en",   64'({mem_en, mem_we}), 64'b10);
        check("t1_ld_addr", 64'(mem_addr), 64'h10);
        next_cycle();
        idle_req();
        @(negedge clk);
        check("t1_lw_valid", 64'(o_cdb_valid), 64'd0);
        check("t1_lw_ready", 64'(i_ready),     64'd0);
        next_cycle();
        @(negedge clk);
        check("t1_cdb_valid", 64'(o_cdb_valid), 64'd1);
        check("t1_cdb",       64'(o_cdb),       {28'd0, 4'd3, 32'hDEADBEEF});
        next_cycle();
        @(negedge clk);
        check("t1_back_idle", 64'({i_ready, o_cdb_valid}), 64'b10);

        // Test 2: four back-to-back stores
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_req(store_ops[i], 4'd0, 32'(i), 32'h100 + 32'(i));
            @(negedge clk);
            check("t2_ready",  64'(i_ready), 64'd1);
            check("t2_we",     64'({mem_en, mem_we}), 64'b11);
            check("t2_addr",   64'(mem_addr), 64'(i));
        end
        next_cycle();
        idle_req();
        @(negedge clk);
        check("t2_we_drop", 64'(mem_en), 64'd0);

        // Test 3: load id 5 of address 1 with CDB stalled for 5 cycles
        next_cycle();
        drive_req(I_LOADB, 4'd5, 32'h1, 32'h0);
        o_cdb_ready = 1'b0;
        next_cycle();
        drive_req(I_STORE, 4'd0, 32'h20, 32'h12345678);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(o_cdb_valid), 64'd1);
            check("t3_hold_cdb",   64'(o_cdb),       {28'd0, 4'd5, 32'h101});
            check("t3_blocked",    64'({i_ready, mem_en}), 64'b00);
            next_cycle();
        end
        o_cdb_ready = 1'b1;
        idle_req();
        @(negedge clk);
        check("t3_release", 64'(o_cdb_valid), 64'd1);
        next_cycle();
        @(negedge clk);
        check("t3_idle", 64'({i_ready, o_cdb_valid}), 64'b10);

        // Test 4: I_OUTPUT with out_ready low 3 cycles
        next_cycle();
        drive_req(I_OUTPUT, 4'd1, 32'h0, 32'h41);
        @(negedge clk);
        check("t4_no_mem", 64'(mem_en), 64'd0);
        next_cycle();
        idle_req();
        for (int i = 0; i < 4; i++) begin
            out_ready = (i == 3);
            @(negedge clk);
            check("t4_out_valid", 64'(out_valid),   64'd1);
            check("t4_out_data",  64'(out_data),    64'h41);
            check("t4_no_cdb",    64'(o_cdb_valid), 64'd0);
            next_cycle();
        end
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_done", 64'({i_ready, out_valid}), 64'b10);

        // Test 5: input-port load id 7, data arrives after 4 cycles
        next_cycle();
        drive_req(I_LOAD, 4'd7, 32'hFFFFFFFF, 32'h0);
        @(negedge clk);
        check("t5_no_mem", 64'(mem_en), 64'd0);
        next_cycle();
        idle_req();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_in_ready", 64'(in_ready), 64'd1);
            next_cycle();
        end
        in_valid = 1'b1;
        in_data  = 32'h55;
        @(negedge clk);
        check("t5_in_take", 64'(in_ready), 64'd1);
        next_cycle();
        in_valid = 1'b0;
        in_data  = 32'hAA;
        @(negedge clk);
        check("t5_cdb_valid", 64'({o_cdb_valid, in_ready}), 64'b10);
        check("t5_cdb",       64'(o_cdb), {28'd0, 4'd7, 32'h55});
        next_cycle();

        // Test 6a: reset while in LOAD_WAIT
        drive_req(I_LOAD, 4'd2, 32'h10, 32'h0);
        next_cycle();
        idle_req();
        rst = 1'b1;
        @(negedge clk);
        check("t6a_rst_outs", 64'({o_cdb_valid, mem_en, i_ready}), 64'b000);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6a_no_late", 64'({o_cdb_valid, i_ready}), 64'b01);
            next_cycle();
        end

        // Test 6b: reset while in RESP
        o_cdb_ready = 1'b0;
        drive_req(I_LOAD, 4'd9, 32'h2, 32'h0);
        next_cycle();
        idle_req();
        next_cycle();
        @(negedge clk);
        check("t6b_resp", 64'(o_cdb), {28'd0, 4'd9, 32'h102});
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("t6b_rst_outs", 64'({o_cdb_valid, mem_en}), 64'b00);
        check("t6b_rst_cdb",  64'(o_cdb), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6b_idle", 64'({i_ready, o_cdb_valid}), 64'b10);
        next_cycle();
        o_cdb_ready = 1'b1;
        @(negedge clk);
        check("t6b_stay_idle", 64'({i_ready, o_cdb_valid}), 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
